// File: rtl/pic_pkg.sv
// pic_pkg: types and defaults shared by the PIC cascade logic.
//   state_e : acknowledge sequence states. P = INTA low, G = gap between pulses.
//   role_e  : role latched at the start of a sequence.
package pic_pkg;
  localparam int CAS_WIDTH_DEF = 3;

  typedef enum logic [2:0] {IDLE, P1, G1, P2, G2, P3} state_e;
  typedef enum logic [1:0] {SINGLE, MASTER, SLAVE}    role_e;
endpackage

// File: rtl/inta_edge_detect.sv
// inta_edge_detect: registers the synchronised INTA strobe and flags its edges.
//   clk, rst_neg : clock, asynchronous active-low reset
//   inta_neg_i   : acknowledge strobe (active low), already in the clk domain
//   fall_o       : inta_neg went high->low this cycle (combinational)
//   rise_o       : inta_neg went low->high this cycle (combinational)
module inta_edge_detect (
  input  logic clk,
  input  logic rst_neg,
  input  logic inta_neg_i,
  output logic fall_o,
  output logic rise_o
);
  logic inta_q;
  logic armed_q;

  // armed_q masks the first cycle after reset: a strobe already low at reset
  // release is a level, not a transition, and must not start a sequence.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      inta_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      inta_q  <= inta_neg_i;
      armed_q <= 1'b1;
    end
  end

  assign fall_o = armed_q & inta_q & ~inta_neg_i;
  assign rise_o = ~inta_q & inta_neg_i;
endmodule

// File: rtl/cascade_sequencer.sv
// cascade_sequencer: tracks the INTA pulse train (2 pulses in 8086 mode,
// 3 in 8080 mode) and decides who drives the cascade bus and the vector.
// Optional watchdog: define CASCADE_TIMEOUT_EN to abort a stalled sequence
// after TIMEOUT_CYCLES cycles without an INTA edge (pulses seq_error).
//   clk, rst_neg          : clock, asynchronous active-low reset
//   single_mode_flag      : 1 = no cascading
//   sp_neg                : 1 = master, 0 = slave
//   mode_8086             : 1 = two-pulse, 0 = three-pulse sequence
//   inta_neg              : acknowledge strobe, synchronised
//   interrupt_id          : winning IR index (master)
//   slaves_connected_flag : bit i = slave on IR i (master)
//   my_slave_id, cas_in   : own ID and sampled cascade bus (slave)
//   cas_out, cas_oe       : cascade bus drive (master)
//   slave_selected        : slave owns this sequence
//   vector_drive_en       : drive the vector on the data bus now
//   inta_phase            : 0 idle, 1..3 current pulse number
//   ack_done, seq_error   : one-cycle completion / abort pulses
module cascade_sequencer
  import pic_pkg::*;
#(
  parameter int CAS_WIDTH      = CAS_WIDTH_DEF,
  parameter int NUM_SLAVES     = 2**CAS_WIDTH,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst_neg,
  input  logic                  single_mode_flag,
  input  logic                  sp_neg,
  input  logic                  mode_8086,
  input  logic                  inta_neg,
  input  logic [CAS_WIDTH-1:0]  interrupt_id,
  input  logic [NUM_SLAVES-1:0] slaves_connected_flag,
  input  logic [CAS_WIDTH-1:0]  my_slave_id,
  input  logic [CAS_WIDTH-1:0]  cas_in,
  output logic [CAS_WIDTH-1:0]  cas_out,
  output logic                  cas_oe,
  output logic                  slave_selected,
  output logic                  vector_drive_en,
  output logic [1:0]            inta_phase,
  output logic                  ack_done,
  output logic                  seq_error
);
  logic fall, rise, start, tmo, owns;

  state_e               state_q, state_d;
  role_e                role_q, role_d;
  logic                 mode_q, mode_d;
  logic                 casc_q, casc_d;
  logic [CAS_WIDTH-1:0] id_q, id_d;

  logic [CAS_WIDTH-1:0] cas_out_q, cas_out_d;
  logic                 cas_oe_q, cas_oe_d;
  logic                 sel_q, sel_d;
  logic                 vde_q, vde_d;
  logic [1:0]           phase_q, phase_d;
  logic                 ack_q, ack_d;
  logic                 err_q;

  inta_edge_detect u_edge (
    .clk        (clk),
    .rst_neg    (rst_neg),
    .inta_neg_i (inta_neg),
    .fall_o     (fall),
    .rise_o     (rise)
  );

  assign start = (state_q == IDLE) && fall;

`ifdef CASCADE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (fall || rise || state_q == IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Fires on the cycle before the count would reach TIMEOUT_CYCLES, so the
  // abort lands exactly TIMEOUT_CYCLES clocks after the last edge.
  assign tmo = (state_q != IDLE) && !(fall || rise) &&
               (cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog; TIMEOUT_CYCLES only keeps both builds on one interface.
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fall) state_d = P1;
      P1:      if (rise) state_d = G1;
      G1:      if (fall) state_d = P2;
      P2:      if (rise) state_d = mode_q ? IDLE : G2;
      G2:      if (fall) state_d = P3;
      P3:      if (rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo) state_d = IDLE;

    // Inputs are captured once per sequence and frozen until IDLE.
    role_d = role_q;
    mode_d = mode_q;
    id_d   = id_q;
    casc_d = casc_q;
    if (start) begin
      if (single_mode_flag) role_d = SINGLE;
      else if (sp_neg)      role_d = MASTER;
      else                  role_d = SLAVE;
      mode_d = mode_8086;
      id_d   = interrupt_id;
      casc_d = slaves_connected_flag[interrupt_id];
    end

    // Slave match is taken from the cycle that ends pulse 1.
    sel_d = sel_q;
    if (state_d == IDLE)
      sel_d = 1'b0;
    else if (state_q == P1 && rise)
      sel_d = (role_q == SLAVE) && (cas_in == my_slave_id);

    // Outputs are derived from next-state so they line up with the state.
    cas_oe_d  = (state_d != IDLE) && (role_d == MASTER) && casc_d;
    cas_out_d = cas_oe_d ? id_d : '0;

    owns  = (role_d == SINGLE) || (role_d == MASTER && !casc_d) ||
            (role_d == SLAVE && sel_d);
    vde_d = (state_d == P2 || state_d == P3) && owns;

    unique case (state_d)
      P1, G1:  phase_d = 2'd1;
      P2, G2:  phase_d = 2'd2;
      P3:      phase_d = 2'd3;
      default: phase_d = 2'd0;
    endcase

    ack_d = rise && ((state_q == P2 && mode_q) || state_q == P3);
  end

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state_q   <= IDLE;
      role_q    <= SINGLE;
      mode_q    <= 1'b0;
      id_q      <= '0;
      casc_q    <= 1'b0;
      cas_out_q <= '0;
      cas_oe_q  <= 1'b0;
      sel_q     <= 1'b0;
      vde_q     <= 1'b0;
      phase_q   <= 2'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      role_q    <= role_d;
      mode_q    <= mode_d;
      id_q      <= id_d;
      casc_q    <= casc_d;
      cas_out_q <= cas_out_d;
      cas_oe_q  <= cas_oe_d;
      sel_q     <= sel_d;
      vde_q     <= vde_d;
      phase_q   <= phase_d;
      ack_q     <= ack_d;
      err_q     <= tmo;
    end
  end

  assign cas_out         = cas_out_q;
  assign cas_oe          = cas_oe_q;
  assign slave_selected  = sel_q;
  assign vector_drive_en = vde_q;
  assign inta_phase      = phase_q;
  assign ack_done        = ack_q;
  assign seq_error       = err_q;
endmodule

// File: tb/tb_cascade_sequencer.sv
module tb_cascade_sequencer;
  logic       clk = 1'b0;
  logic       rst_neg;
  logic       single_mode_flag, sp_neg, mode_8086, inta_neg;
  logic [2:0] interrupt_id, my_slave_id, cas_in, cas_out;
  logic [7:0] slaves_connected_flag;
  logic       cas_oe, slave_selected, vector_drive_en, ack_done, seq_error;
  logic [1:0] inta_phase;

  int nvec = 0;
  int nmis = 0;

  cascade_sequencer #(.CAS_WIDTH(3), .NUM_SLAVES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk                   (clk),
    .rst_neg               (rst_neg),
    .single_mode_flag      (single_mode_flag),
    .sp_neg                (sp_neg),
    .mode_8086             (mode_8086),
    .inta_neg              (inta_neg),
    .interrupt_id          (interrupt_id),
    .slaves_connected_flag (slaves_connected_flag),
    .my_slave_id           (my_slave_id),
    .cas_in                (cas_in),
    .cas_out               (cas_out),
    .cas_oe                (cas_oe),
    .slave_selected        (slave_selected),
    .vector_drive_en       (vector_drive_en),
    .inta_phase            (inta_phase),
    .ack_done              (ack_done),
    .seq_error             (seq_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1ns after posedge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fall();
    inta_neg = 1'b0;
    step(1);
  endtask

  task automatic rise();
    inta_neg = 1'b1;
    step(1);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_out"},   cas_out, 0);
    chk({tag, "_oe"},    cas_oe, 0);
    chk({tag, "_sel"},   slave_selected, 0);
    chk({tag, "_vde"},   vector_drive_en, 0);
    chk({tag, "_phase"}, inta_phase, 0);
    chk({tag, "_ack"},   ack_done, 0);
    chk({tag, "_err"},   seq_error, 0);
  endtask

  initial begin
    rst_neg = 1'b0; inta_neg = 1'b1;
    single_mode_flag = 1'b0; sp_neg = 1'b1; mode_8086 = 1'b1;
    interrupt_id = 3'd3; slaves_connected_flag = 8'b0000_1000;
    my_slave_id = 3'd0; cas_in = 3'd0;
    #3;
    all_zero("rst");
    step(2);
    rst_neg = 1'b1;
    step(2);

    // Master 8086, cascaded IR3
    fall();
    chk("m86_p1_oe", cas_oe, 1);
    chk("m86_p1_out", cas_out, 3);
    chk("m86_p1_phase", inta_phase, 1);
    step(2);
    chk("m86_p1_oe_hold", cas_oe, 1);
    rise();
    chk("m86_g1_phase", inta_phase, 1);
    chk("m86_g1_oe", cas_oe, 1);
    step(2);
    fall();
    chk("m86_p2_phase", inta_phase, 2);
    chk("m86_p2_out", cas_out, 3);
    chk("m86_p2_vde", vector_drive_en, 0);
    rise();
    chk("m86_end_ack", ack_done, 1);
    chk("m86_end_oe", cas_oe, 0);
    chk("m86_end_phase", inta_phase, 0);
    step(1);
    chk("m86_ack_once", ack_done, 0);
    step(2);

    // Master 8080, IR5 not cascaded
    mode_8086 = 1'b0; interrupt_id = 3'd5; slaves_connected_flag = 8'h00;
    fall();
    chk("m80_p1_oe", cas_oe, 0);
    chk("m80_p1_phase", inta_phase, 1);
    chk("m80_p1_vde", vector_drive_en, 0);
    rise(); step(1);
    fall();
    chk("m80_p2_phase", inta_phase, 2);
    chk("m80_p2_vde", vector_drive_en, 1);
    chk("m80_p2_oe", cas_oe, 0);
    rise();
    chk("m80_g2_vde", vector_drive_en, 0);
    chk("m80_g2_ack", ack_done, 0);
    step(1);
    fall();
    chk("m80_p3_phase", inta_phase, 3);
    chk("m80_p3_vde", vector_drive_en, 1);
    rise();
    chk("m80_end_phase", inta_phase, 0);
    chk("m80_end_ack", ack_done, 1);
    step(2);

    // Slave, match
    sp_neg = 1'b0; mode_8086 = 1'b1; my_slave_id = 3'd2; cas_in = 3'd2;
    fall();
    chk("sl_p1_sel", slave_selected, 0);
    chk("sl_p1_oe", cas_oe, 0);
    rise();
    chk("sl_g1_sel", slave_selected, 1);
    cas_in = 3'd0;
    step(2);
    chk("sl_g1_sel_hold", slave_selected, 1);
    fall();
    chk("sl_p2_vde", vector_drive_en, 1);
    chk("sl_p2_oe", cas_oe, 0);
    rise();
    chk("sl_end_ack", ack_done, 1);
    chk("sl_end_sel", slave_selected, 0);
    step(2);

    // Slave, no match
    cas_in = 3'd6;
    fall(); rise();
    chk("sln_g1_sel", slave_selected, 0);
    step(1);
    fall();
    chk("sln_p2_vde", vector_drive_en, 0);
    chk("sln_p2_sel", slave_selected, 0);
    rise(); step(2);

    // Single mode
    single_mode_flag = 1'b1; sp_neg = 1'b1; slaves_connected_flag = 8'hFF;
    fall(); rise(); step(1); fall();
    chk("sgl_p2_vde", vector_drive_en, 1);
    chk("sgl_p2_oe", cas_oe, 0);
    rise();
    chk("sgl_end_ack", ack_done, 1);
    step(2);

    // Reset while in G1
    single_mode_flag = 1'b0; interrupt_id = 3'd3; slaves_connected_flag = 8'b0000_1000;
    fall(); rise();
    chk("rg1_oe_before", cas_oe, 1);
    step(1);
    #2 rst_neg = 1'b0;
    #1;
    all_zero("rg1");
    step(1);
    rst_neg = 1'b1;
    step(2);
    all_zero("rg1_idle");
    fall();
    chk("rg1_restart_phase", inta_phase, 1);
    chk("rg1_restart_oe", cas_oe, 1);
    rise(); step(1); fall(); rise(); step(2);

    // inta_neg low at reset release is a level, not an edge
    rst_neg = 1'b0; inta_neg = 1'b0;
    step(2);
    rst_neg = 1'b1;
    step(3);
    chk("lowrel_phase", inta_phase, 0);
    rise(); fall();
    chk("lowrel_start_phase", inta_phase, 1);
    rise(); step(1); fall(); rise(); step(2);

    // Watchdog / indefinite wait after pulse 1
    fall(); rise();
`ifdef CASCADE_TIMEOUT_EN
    step(15);
    chk("tmo_err_early", seq_error, 0);
    chk("tmo_phase_early", inta_phase, 1);
    step(1);
    chk("tmo_err", seq_error, 1);
    chk("tmo_oe", cas_oe, 0);
    chk("tmo_phase", inta_phase, 0);
    step(1);
    chk("tmo_err_once", seq_error, 0);
    step(2);
`else
    step(40);
    chk("wait_err", seq_error, 0);
    chk("wait_phase", inta_phase, 1);
    chk("wait_oe", cas_oe, 1);
    fall(); rise();
    chk("wait_end_ack", ack_done, 1);
    step(2);
`endif

    // interrupt_id changes mid-sequence, then back-to-back start
    slaves_connected_flag = 8'b0001_1000; interrupt_id = 3'd3;
    fall(); rise();
    interrupt_id = 3'd4;
    step(1);
    chk("idchg_g1_out", cas_out, 3);
    fall();
    chk("idchg_p2_out", cas_out, 3);
    rise();
    chk("idchg_end_ack", ack_done, 1);
    fall();
    chk("b2b_phase", inta_phase, 1);
    chk("b2b_out", cas_out, 4);
    rise(); step(1); fall(); rise();
    chk("b2b_end_ack", ack_done, 1);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/cascade_sequencer.md
# cascade_sequencer

Clocked, parametrised successor to the combinational cascade-line handler in the PIC. It tracks the INTA pulse sequence and selects the device that supplies the vector. It supports both processor modes: two INTA pulses (8086) and three INTA pulses (8080).
- Master role: latches the winning interrupt ID and drives it on the cascade bus for the whole acknowledge sequence.
- Slave role: samples the cascade bus during the first INTA and decides whether it owns the vector.
- It sits between the priority resolver and the data-bus buffer control.

## Interface
Parameters:
- CAS_WIDTH, 3, width of cascade bus and interrupt/slave IDs
- NUM_SLAVES, 2**CAS_WIDTH, width of slaves_connected_flag
- TIMEOUT_CYCLES, 1023, abort threshold (used only with timeout compiled in)

Ports:
- clk  in  1  single system clock
- rst_neg  in  1  asynchronous, active-low reset
- single_mode_flag  in  1  1 = no cascading
- sp_neg  in  1  1 = master, 0 = slave
- mode_8086  in  1  1 = two-pulse sequence, 0 = three-pulse sequence
- inta_neg  in  1  acknowledge strobe, already synchronised to clk
- interrupt_id  in  CAS_WIDTH  winning IR index (master)
- slaves_connected_flag  in  NUM_SLAVES  bit i = slave on IR i (master)
- my_slave_id  in  CAS_WIDTH  this device's ID (slave)
- cas_in  in  CAS_WIDTH  cascade bus sampled value
- cas_out  out  CAS_WIDTH  cascade bus drive value
- cas_oe  out  1  cascade bus output enable
- slave_selected  out  1  slave matched the cascade ID for this sequence
- vector_drive_en  out  1  this device drives the data bus now
- inta_phase  out  2  0 idle, 1/2/3 = current INTA pulse number
- ack_done  out  1  one-cycle pulse when the sequence completes
- seq_error  out  1  one-cycle pulse on timeout abort

## Operation
- Edge detect:
  - Register inta_q (reset 1).
  - Falling edge: inta_q=1 and inta_neg=0.
  - Rising edge: inta_q=0 and inta_neg=1.
- Role latch: at the first falling edge, latch role, mode, interrupt_id and cascaded = slaves_connected_flag[interrupt_id]. Role is SINGLE, MASTER or SLAVE. Input changes after that point are ignored until IDLE.
- FSM states: IDLE, P1, G1, P2, G2, P3.
  - IDLE→P1 on falling edge.
  - P1→G1 on rising edge.
  - G1→P2 on falling edge.
  - P2→IDLE on rising edge if mode_8086, else P2→G2.
  - G2→P3 on falling edge.
  - P3→IDLE on rising edge.
- ack_done pulses on the final rising edge.
- MASTER:
  - cas_out = latched ID, cas_oe = 1 from P1 entry until return to IDLE, only if cascaded.
  - Otherwise cas_out = 0 and cas_oe = 0.
- SLAVE:
  - Compare cas_in to my_slave_id every cycle in P1.
  - The value on the P1→G1 transition cycle is latched into slave_selected.
  - slave_selected stays held until IDLE.
  - cas_oe is always 0.
- SINGLE: cas_oe = 0; device always owns the vector.
- vector_drive_en is high in P2 (8086), or P2 and P3 (8080), when any of these holds:
  - role SINGLE;
  - MASTER and not cascaded;
  - SLAVE and slave_selected.
- inta_phase: P1/G1 = 1, P2/G2 = 2, P3 = 3, IDLE = 0.

## Timing
- All outputs registered; reset value of every output is 0. FSM resets to IDLE, inta_q to 1.
- Latency: the state change and outputs appear the cycle after the edge is sampled, so cas_oe rises 1 clk after the first falling edge of inta_neg.
- Reset mid-sequence: immediate return to IDLE; cas_oe drops asynchronously; no ack_done.
- inta_neg low at reset release: not treated as an edge; the sequence starts only after a high→low transition.
- Back-to-back sequences: a falling edge in the cycle after the return to IDLE starts a new P1 with freshly latched inputs.

## Configuration
- CASCADE_TIMEOUT_EN defined:
  - A counter (reset 0) clears on every INTA edge and increments in every non-IDLE state.
  - At TIMEOUT_CYCLES the FSM returns to IDLE, all drives drop and seq_error pulses once.
- CASCADE_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely and seq_error is tied 0.

## Structure
- Shared package pic_pkg holds:
  - the state enum (IDLE, P1, G1, P2, G2, P3);
  - the role enum (SINGLE, MASTER, SLAVE);
  - the default CAS_WIDTH constant.
- One sub-module, inta_edge_detect: registers inta_neg and emits fall/rise pulses.

## Test plan
- Master, 8086, interrupt_id=3, flags=8'b0000_1000, two INTA pulses:
  - cas_out=3 and cas_oe=1 from 1 clk after the first fall until the second rise;
  - vector_drive_en=0;
  - ack_done pulses once.
- Master, 8080, interrupt_id=5, flags=0:
  - cas_oe stays 0;
  - vector_drive_en=1 during pulses 2 and 3;
  - inta_phase steps 1,2,3,0.
- Slave, my_slave_id=2, cas_in=2 during pulse 1: slave_selected=1 and vector_drive_en=1 in P2. Repeat with cas_in=6: both stay 0.
- rst_neg asserted while in G1: all outputs 0 immediately; the next falling edge starts at P1.
- With CASCADE_TIMEOUT_EN and TIMEOUT_CYCLES=16, stop after pulse 1:
  - seq_error pulses 16 cycles after the last edge;
  - cas_oe drops and the FSM is in IDLE.
- interrupt_id changed from 3 to 4 during G1: cas_out holds 3 for the whole sequence.
